// File: rtl/dma_read_master_pipelined.sv
// Pipelined Avalon-MM read master feeding a downstream write FIFO.
// FIFO credits bound outstanding reads so no returned beat is ever dropped.
module dma_read_master_pipelined #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 32,
    parameter int MAX_PENDING = 4,
    parameter int FIFO_DEPTH  = 64,
    parameter int FIFO_AW     = 7
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic [LEN_W-1:0]  iLength,
    input  logic [ADDR_W-1:0] iStartAddress,
    output logic              oBusy,
    output logic              oDone,
    output logic              oError,
    output logic              oRM_read,
    output logic [ADDR_W-1:0] oRM_address,
    input  logic              iRM_waitrequest,
    input  logic              iRM_readdatavalid,
    input  logic [DATA_W-1:0] iRM_readdata,
    input  logic [FIFO_AW-1:0] iFF_usedw,
    output logic              oFF_writerequest,
    output logic [DATA_W-1:0] oFF_data
);
    localparam int BYTES = DATA_W / 8;
    localparam int PW    = $clog2(MAX_PENDING + 1);
    localparam int CW    = ((FIFO_AW > PW) ? FIFO_AW : PW) + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_remaining;
    logic [PW-1:0]     r_pending;
    logic              r_hold;
    logic              r_abort;
    logic              r_done;
    logic              r_error;
    logic              r_ffwr;
    logic [DATA_W-1:0] r_ffdata;

    logic [ADDR_W-1:0] w_addr_al;
    logic [LEN_W-1:0]  w_len_al;
    logic [CW-1:0]     w_fill;
    logic              w_credit;
    logic              w_abort;
    logic              w_read;
    logic              w_acc;
    logic              w_ret;
    logic              w_stray;
    logic              w_last;
    logic              w_done;
    logic              w_start;

    assign w_addr_al = iStartAddress & ~ADDR_W'(BYTES - 1);
    assign w_len_al  = iLength & ~LEN_W'(BYTES - 1);

    // A beat sitting in the output register is neither pending nor in usedw yet
    assign w_fill = CW'(iFF_usedw) + CW'(r_pending) + CW'(r_ffwr);

    always_comb begin
        w_credit = (r_remaining != '0)
                && (r_pending < PW'(MAX_PENDING))
                && (w_fill < CW'(FIFO_DEPTH));
        w_abort  = iAbort | r_abort;
        w_read   = (r_state == S_ISSUE)
                && (r_hold || (w_credit && !w_abort));
        w_acc    = w_read && !iRM_waitrequest;
        w_ret    = iRM_readdatavalid && (r_pending != '0);
        w_stray  = iRM_readdatavalid && (r_pending == '0);
        w_last   = (r_remaining == LEN_W'(BYTES));
        w_done   = (r_state == S_DRAIN) && (r_pending == '0) && !r_ffwr;
        w_start  = (r_state == S_IDLE) && iStart;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (iStart)
                    w_state_nxt = (w_len_al == '0) ? S_DRAIN : S_ISSUE;
            end
            S_ISSUE: begin
                if ((r_remaining == '0)
                    || (w_acc && (w_last || w_abort))
                    || (w_abort && !w_read))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_done)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_pending   <= '0;
            r_hold      <= 1'b0;
            r_abort     <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_ffwr      <= 1'b0;
            r_ffdata    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done;
            r_ffwr    <= w_ret;
            r_hold    <= w_read && iRM_waitrequest;
            r_pending <= r_pending + PW'(w_acc) - PW'(w_ret);
            if (iRM_readdatavalid)
                r_ffdata <= iRM_readdata;
            if (w_stray)
                r_error <= 1'b1;
            if ((r_state == S_ISSUE) && iAbort)
                r_abort <= 1'b1;
            if (w_start) begin
                r_addr      <= w_addr_al;
                r_remaining <= w_len_al;
                r_error     <= 1'b0;
                r_abort     <= 1'b0;
            end else if (w_acc) begin
                r_addr      <= r_addr + ADDR_W'(BYTES);
                r_remaining <= r_remaining - LEN_W'(BYTES);
            end
        end
    end

    assign oBusy            = (r_state != S_IDLE);
    assign oDone            = r_done;
    assign oError           = r_error;
    assign oRM_read         = w_read;
    assign oRM_address      = r_addr;
    assign oFF_writerequest = r_ffwr;
    assign oFF_data         = r_ffdata;

endmodule
